// File: rtl/ram_wb_b3_arbiter.sv
// Two-master Wishbone B3 arbiter in front of a single RAM slave.
// Grant is held for the whole cyc, so bursts stay intact; an optional watchdog aborts stalls with err.
module ram_wb_b3_arbiter #(
   parameter int unsigned dw      = 32,
   parameter int unsigned aw      = 32,
   parameter int unsigned TIMEOUT = 0,
   parameter int unsigned TO_W    = 8
) (
   input  logic          wb_clk_i,
   input  logic          wb_rst_n_i,
   // master 0
   input  logic [aw-1:0] m0_adr_i,
   input  logic [1:0]    m0_bte_i,
   input  logic [2:0]    m0_cti_i,
   input  logic          m0_cyc_i,
   input  logic          m0_stb_i,
   input  logic          m0_we_i,
   input  logic [3:0]    m0_sel_i,
   input  logic [dw-1:0] m0_dat_i,
   output logic [dw-1:0] m0_dat_o,
   output logic          m0_ack_o,
   output logic          m0_err_o,
   output logic          m0_rty_o,
   // master 1
   input  logic [aw-1:0] m1_adr_i,
   input  logic [1:0]    m1_bte_i,
   input  logic [2:0]    m1_cti_i,
   input  logic          m1_cyc_i,
   input  logic          m1_stb_i,
   input  logic          m1_we_i,
   input  logic [3:0]    m1_sel_i,
   input  logic [dw-1:0] m1_dat_i,
   output logic [dw-1:0] m1_dat_o,
   output logic          m1_ack_o,
   output logic          m1_err_o,
   output logic          m1_rty_o,
   // slave
   output logic [aw-1:0] s_adr_o,
   output logic [1:0]    s_bte_o,
   output logic [2:0]    s_cti_o,
   output logic          s_cyc_o,
   output logic          s_stb_o,
   output logic          s_we_o,
   output logic [3:0]    s_sel_o,
   output logic [dw-1:0] s_dat_o,
   input  logic          s_ack_i,
   input  logic          s_err_i,
   input  logic          s_rty_i,
   input  logic [dw-1:0] s_dat_i
);

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StGnt0 = 2'd1,
      StGnt1 = 2'd2
   } state_e;

   localparam bit              WdEn   = (TIMEOUT != 0);
   localparam logic [TO_W-1:0] WdLast = WdEn ? TO_W'(TIMEOUT - 1) : '0;

   state_e          r_state;
   state_e          w_state_d;
   logic            r_last;
   logic            w_last_d;
   logic [TO_W-1:0] r_wd_cnt;
   logic [TO_W-1:0] w_wd_cnt_d;

   logic            w_gnt0;
   logic            w_gnt1;
   logic            w_cyc;
   logic            w_stb;
   logic            w_resp;
   logic            w_wd_fire;

   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         r_state  <= StIdle;
         r_last   <= 1'b1;
         r_wd_cnt <= '0;
      end else begin
         r_state  <= w_state_d;
         r_last   <= w_last_d;
         r_wd_cnt <= w_wd_cnt_d;
      end
   end

   // r_last names the master that most recently released; ties go to the other one.
   always_comb begin
      w_state_d = r_state;
      w_last_d  = r_last;
      case (r_state)
         StIdle: begin
            if (m0_cyc_i && m1_cyc_i) begin
               w_state_d = r_last ? StGnt0 : StGnt1;
            end else if (m0_cyc_i) begin
               w_state_d = StGnt0;
            end else if (m1_cyc_i) begin
               w_state_d = StGnt1;
            end
         end
         StGnt0: begin
            if (!m0_cyc_i) begin
               w_last_d  = 1'b0;
               w_state_d = m1_cyc_i ? StGnt1 : StIdle;
            end
         end
         StGnt1: begin
            if (!m1_cyc_i) begin
               w_last_d  = 1'b1;
               w_state_d = m0_cyc_i ? StGnt0 : StIdle;
            end
         end
         default: w_state_d = StIdle;
      endcase
   end

   assign w_gnt0 = (r_state == StGnt0);
   assign w_gnt1 = (r_state == StGnt1);
   assign w_cyc  = (w_gnt0 & m0_cyc_i) | (w_gnt1 & m1_cyc_i);
   assign w_stb  = (w_gnt0 & m0_stb_i) | (w_gnt1 & m1_stb_i);
   assign w_resp = s_ack_i | s_err_i | s_rty_i;

   assign w_wd_fire = WdEn && (r_wd_cnt == WdLast) && w_stb && !w_resp;

   always_comb begin
      w_wd_cnt_d = r_wd_cnt;
      if (!WdEn || (w_state_d != r_state) || w_resp || !w_stb || w_wd_fire) begin
         w_wd_cnt_d = '0;
      end else if (r_wd_cnt != '1) begin
         w_wd_cnt_d = r_wd_cnt + 1'b1;
      end
   end

   // Idle parks the address/data path on master 0; cyc/stb stay low.
   always_comb begin
      if (w_gnt1) begin
         s_adr_o = m1_adr_i;
         s_bte_o = m1_bte_i;
         s_cti_o = m1_cti_i;
         s_we_o  = m1_we_i;
         s_sel_o = m1_sel_i;
         s_dat_o = m1_dat_i;
      end else begin
         s_adr_o = m0_adr_i;
         s_bte_o = m0_bte_i;
         s_cti_o = m0_cti_i;
         s_we_o  = m0_we_i;
         s_sel_o = m0_sel_i;
         s_dat_o = m0_dat_i;
      end
   end

   assign s_cyc_o = w_cyc;
   assign s_stb_o = w_stb & ~w_wd_fire;

   assign m0_dat_o = s_dat_i;
   assign m1_dat_o = s_dat_i;

   assign m0_ack_o = w_gnt0 & s_ack_i;
   assign m0_err_o = w_gnt0 & (s_err_i | w_wd_fire);
   assign m0_rty_o = w_gnt0 & s_rty_i;

   assign m1_ack_o = w_gnt1 & s_ack_i;
   assign m1_err_o = w_gnt1 & (s_err_i | w_wd_fire);
   assign m1_rty_o = w_gnt1 & s_rty_i;

endmodule
